brent_kung_32bitt: RTL and testbench

BRENT_KUNG_32BITT -- requirements
Module: brent_kung_32bitt

---
 rtl/brent_kung_32bitt_if.sv | 7 +
 rtl/brent_kung_32bitt.sv | 32 +++
 tb/tb_brent_kung_32bitt.sv | 80 ++++++++
 3 files changed

// File: rtl/brent_kung_32bitt_if.sv
// brent_kung_32bitt_if: adder bus; a, b, cin operands from master, registered s, cout result from slave
interface brent_kung_32bitt_if;
  logic [31:0] a, b, s;
  logic cin, cout;
  modport master (output a, b, cin, input s, cout);
  modport slave (input a, b, cin, output s, cout);
endinterface

// File: rtl/brent_kung_32bitt.sv
// brent_kung_32bitt: registered 32-bit Brent-Kung adder; ports clk, rst (async high), bus.slave {a, b, cin -> s, cout}
module brent_kung_32bitt (
  input  logic clk,
  input  logic rst,
  brent_kung_32bitt_if.slave bus
);
  logic [31:0] p, g, pp;
  always_comb begin
    p = bus.a ^ bus.b;
    g = bus.a & bus.b;
    g[0] = g[0] | (p[0] & bus.cin);
    pp = p;
    for (int k = 0; k < 5; k++)
      for (int i = (2 << k) - 1; i < 32; i += (2 << k)) begin
        g[i] = g[i] | (pp[i] & g[i - (1 << k)]);
        pp[i] = pp[i] & pp[i - (1 << k)];
      end
    for (int k = 3; k >= 0; k--)
      for (int i = 3 * (1 << k) - 1; i < 32; i += (2 << k)) begin
        g[i] = g[i] | (pp[i] & g[i - (1 << k)]);
        pp[i] = pp[i] & pp[i - (1 << k)];
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.s <= '0;
      bus.cout <= 1'b0;
    end else begin
      bus.s <= p ^ {g[30:0], bus.cin};
      bus.cout <= g[31];
    end
endmodule

// File: tb/tb_brent_kung_32bitt.sv
// tb_brent_kung_32bitt: scoreboard bench for brent_kung_32bitt
module tb_brent_kung_32bitt;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [32:0] q[$];
  logic [32:0] last = '0;
  brent_kung_32bitt_if bus ();
  brent_kung_32bitt dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (!rst && q.size() > 0) begin
      last = q.pop_front();
      check("sum", {bus.cout, bus.s}, last);
    end
  end
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c, input logic [32:0] exp);
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.cin = c;
    q.push_back(exp);
    #1 check("hold", {bus.cout, bus.s}, last);
  endtask
  initial begin
    logic [31:0] ra, rb;
    logic rc;
    bus.a = 32'h1234_5678;
    bus.b = 32'h9ABC_DEF0;
    bus.cin = 1'b1;
    #2 rst = 1'b1;
    #1 check("rst_async", {bus.cout, bus.s}, 33'h0);
    @(negedge clk);
    check("rst_hold", {bus.cout, bus.s}, 33'h0);
    rst = 1'b0;
    q.push_back(33'h0_ACF1_3569);
    drive(32'h0000_1234, 32'h0000_5678, 1'b0, 33'h0_0000_68AC);
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000);
    drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 33'h0_FFFF_FFFF);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE);
    drive(32'hDEAD_BEEF, 32'hCAFE_BABE, 1'b0, 33'h1_A9AC_79AD);
    drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
    drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33'h0_FFFF_FFFF);
    drive(32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000);
    drive(32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0001);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
    drive(32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000);
    drive(32'hDEAD_BEEF, 32'hCAFE_BABE, 1'b1, 33'h1_A9AC_79AE);
    #1 rst = 1'b1;
    q.delete();
    last = '0;
    #1 check("rst_mid", {bus.cout, bus.s}, 33'h0);
    @(posedge clk);
    #2 check("rst_edge", {bus.cout, bus.s}, 33'h0);
    @(negedge clk);
    rst = 1'b0;
    q.push_back(33'h1_A9AC_79AE);
    drive(32'h0000_0001, 32'h0000_0002, 1'b1, 33'h0_0000_0004);
    repeat (10000) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      drive(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {32'h0, rc});
    end
    @(negedge clk);
    @(negedge clk);
    check("drain", 33'(q.size()), 33'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
